uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small TX FIFO. Bit time is div_i cycles (min 2),
// latched per frame; back-to-back frames start straight out of the stop bit.
module uart_tx #(
   parameter int DEPTH = 4,
   parameter int DIVW  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_i,
   input  logic [7:0]             data_i,
   input  logic [DIVW-1:0]        div_i,
   input  logic                   ovf_clr_i,
   output logic                   tx_o,
   output logic                   busy_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   overflow_o
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_reg, state_next;
   logic [DIVW-1:0] cnt_reg, cnt_next;
   logic [DIVW-1:0] div_reg, div_next;
   logic [2:0]      bit_reg, bit_next;
   logic [7:0]      shift_reg, shift_next;
   logic            tx_reg, tx_next;

   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]     level_reg;
   logic            ovf_reg;

   logic            pop, push, full, bit_end;
   logic [DIVW-1:0] div_eff;

   assign full    = (level_reg == (AW+1)'(DEPTH));
   assign push    = wr_i && !full && !reset;
   assign div_eff = (div_i < DIVW'(2)) ? DIVW'(2) : div_i;
   assign bit_end = (cnt_reg == div_reg - DIVW'(1));

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + DIVW'(1);
      div_next   = div_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      tx_next    = tx_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            tx_next  = 1'b1;
            if (level_reg != '0) begin
               pop        = 1'b1;
               state_next = START;
               tx_next    = 1'b0;
               div_next   = div_eff;
               shift_next = mem[rd_ptr_reg];
            end
         end
         START: begin
            if (bit_end) begin
               cnt_next   = '0;
               bit_next   = 3'd0;
               state_next = DATA;
               tx_next    = shift_reg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_next = '0;
               if (bit_reg == 3'd7) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_next = bit_reg + 3'd1;
                  tx_next  = shift_reg[bit_reg + 3'd1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_next = '0;
               bit_next = 3'd0;
               // Chain straight into the next start bit when more data waits.
               if (level_reg != '0) begin
                  pop        = 1'b1;
                  state_next = START;
                  tx_next    = 1'b0;
                  div_next   = div_eff;
                  shift_next = mem[rd_ptr_reg];
               end else begin
                  state_next = IDLE;
                  tx_next    = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         div_reg   <= DIVW'(2);
         bit_reg   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         div_reg   <= div_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         tx_reg    <= tx_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (push && !pop)      level_reg <= level_reg + (AW+1)'(1);
         else if (!push && pop) level_reg <= level_reg - (AW+1)'(1);
         // A dropped write wins over a clear arriving on the same edge.
         if (wr_i && full)   ovf_reg <= 1'b1;
         else if (ovf_clr_i) ovf_reg <= 1'b0;
      end
   end

   assign tx_o       = tx_reg;
   assign busy_o     = (state_reg != IDLE);
   assign full_o     = full;
   assign level_o    = level_reg;
   assign overflow_o = ovf_reg;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model checks every
// cycle, plus a FIFO vector table and directed multi-cycle sequences.
module tb_uart_tx;
   localparam int DEPTH = 4;
   localparam int DIVW  = 16;

   logic        clk = 1'b0;
   logic        reset, wr_i, ovf_clr_i;
   logic [7:0]  data_i;
   logic [15:0] div_i;
   logic        tx_o, busy_o, full_o, overflow_o;
   logic [2:0]  level_o;

   uart_tx #(.DEPTH(DEPTH), .DIVW(DIVW)) dut (
      .clk(clk), .reset(reset), .wr_i(wr_i), .data_i(data_i), .div_i(div_i),
      .ovf_clr_i(ovf_clr_i), .tx_o(tx_o), .busy_o(busy_o), .full_o(full_o),
      .level_o(level_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a byte queue plus the frame in flight, timed by elapsed cycles.
   logic [7:0] m_q[$];
   bit         m_active;
   int         m_elapsed, m_div;
   logic [7:0] m_byte;
   bit         m_ovf;

   logic tx_hist   [256];
   logic busy_hist [256];
   int   lvl_hist  [256];
   int   seq_k;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic model_tx();
      int k;
      if (!m_active) return 1'b1;
      k = m_elapsed / m_div;
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return m_byte[k-1];
   endfunction

   function automatic void model_edge(logic wr, logic [7:0] d, logic [15:0] dv, logic clr, logic rst);
      int pre = m_q.size();
      bit pop = (pre > 0) && (!m_active || m_elapsed == 10*m_div - 1);
      if (rst) begin
         m_q.delete();
         m_active = 0; m_elapsed = 0; m_ovf = 0;
         return;
      end
      if (m_active) begin
         m_elapsed++;
         if (m_elapsed >= 10*m_div) m_active = 0;
      end
      if (pop) begin
         m_byte    = m_q.pop_front();
         m_active  = 1;
         m_elapsed = 0;
         m_div     = (dv < 2) ? 2 : int'(dv);
      end
      if (wr && pre == DEPTH) m_ovf = 1;
      else begin
         if (wr)  m_q.push_back(d);
         if (clr) m_ovf = 0;
      end
   endfunction

   task automatic step(input logic wr, input logic [7:0] d, input logic [15:0] dv,
                       input logic clr, input logic rst);
      wr_i = wr; data_i = d; div_i = dv; ovf_clr_i = clr; reset = rst;
      @(posedge clk);
      model_edge(wr, d, dv, clr, rst);
      #1;
      chk("tx",       tx_o,       model_tx());
      chk("busy",     busy_o,     m_active);
      chk("level",    level_o,    m_q.size());
      chk("full",     full_o,     m_q.size() == DEPTH);
      chk("overflow", overflow_o, m_ovf);
      if (seq_k < 256) begin
         tx_hist[seq_k] = tx_o; busy_hist[seq_k] = busy_o; lvl_hist[seq_k] = int'(level_o);
      end
      seq_k++;
   endtask

   task automatic do_reset();
      step(0, 8'h00, 16'd4, 0, 1);
      step(0, 8'h00, 16'd4, 0, 1);
      seq_k = 0;
   endtask

   typedef struct {
      logic wr; logic [7:0] data; logic clr;
      logic tx; logic busy; int level; logic full; logic ovf;
   } vec_t;
   vec_t vecs[9];

   initial begin
      logic [9:0] fr0, fr1;
      int lows;
      vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b1};
      vecs[6] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0};
      seq_k = 0;

      do_reset();
      chk("reset_tx", tx_o, 1'b1);
      chk("reset_level", level_o, 0);

      // FIFO fill / overflow / clear at a long bit time
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].wr, vecs[i].data, 16'd100, vecs[i].clr, 0);
         chk("vec_tx",    tx_o,       vecs[i].tx);
         chk("vec_busy",  busy_o,     vecs[i].busy);
         chk("vec_level", level_o,    vecs[i].level);
         chk("vec_full",  full_o,     vecs[i].full);
         chk("vec_ovf",   overflow_o, vecs[i].ovf);
         $display("vector %0d: wr=%0d data=%02h clr=%0d level=%0d ovf=%0d",
                  i, vecs[i].wr, vecs[i].data, vecs[i].clr, level_o, overflow_o);
      end

      // 0xA5 at div 4
      do_reset();
      step(1, 8'hA5, 16'd4, 0, 0);
      repeat (45) step(0, 8'h00, 16'd4, 0, 0);
      fr0 = {1'b1, 8'hA5, 1'b0};
      chk("a5_lvl0", lvl_hist[0], 1);
      chk("a5_tx0", tx_hist[0], 1'b1);
      for (int k = 1; k <= 40; k++) chk("a5_tx", tx_hist[k], fr0[(k-1)/4]);
      chk("a5_busy40", busy_hist[40], 1'b1);
      chk("a5_busy41", busy_hist[41], 1'b0);
      $display("sequence: 0xA5 frame at div 4 done");

      // back-to-back 0x00, 0xFF at div 2
      do_reset();
      step(1, 8'h00, 16'd2, 0, 0);
      step(1, 8'hFF, 16'd2, 0, 0);
      repeat (45) step(0, 8'h00, 16'd2, 0, 0);
      fr0 = {1'b1, 8'h00, 1'b0};
      fr1 = {1'b1, 8'hFF, 1'b0};
      chk("b2b_lvl0", lvl_hist[0], 1);
      chk("b2b_lvl1", lvl_hist[1], 1);
      chk("b2b_lvl21", lvl_hist[21], 0);
      for (int k = 1; k <= 40; k++)
         chk("b2b_tx", tx_hist[k], (k <= 20) ? fr0[(k-1)/2] : fr1[(k-21)/2]);
      chk("b2b_busy41", busy_hist[41], 1'b0);
      $display("sequence: back-to-back frames at div 2 done");

      // div 0 clamps to 2
      do_reset();
      step(1, 8'h5A, 16'd0, 0, 0);
      repeat (25) step(0, 8'h00, 16'd0, 0, 0);
      fr0 = {1'b1, 8'h5A, 1'b0};
      for (int k = 1; k <= 20; k++) chk("clamp_tx", tx_hist[k], fr0[(k-1)/2]);
      chk("clamp_busy20", busy_hist[20], 1'b1);
      chk("clamp_busy21", busy_hist[21], 1'b0);
      $display("sequence: div 0 clamp done");

      // reset mid-frame with two bytes queued
      do_reset();
      step(1, 8'h3C, 16'd4, 0, 0);
      step(1, 8'h81, 16'd4, 0, 0);
      step(1, 8'hC3, 16'd4, 0, 0);
      repeat (13) step(0, 8'h00, 16'd4, 0, 0);
      chk("rst_lvl_before", lvl_hist[15], 2);
      step(1, 8'h99, 16'd4, 0, 1);
      chk("rst_tx", tx_o, 1'b1);
      chk("rst_level", level_o, 0);
      chk("rst_busy", busy_o, 1'b0);
      repeat (50) step(0, 8'h00, 16'd4, 0, 0);
      lows = 0;
      for (int k = 17; k < 67; k++) if (tx_hist[k] !== 1'b1) lows++;
      chk("rst_no_start", lows, 0);
      $display("sequence: reset mid-frame done");

      // div 4 -> 8 mid-frame
      do_reset();
      step(1, 8'h96, 16'd4, 0, 0);
      step(1, 8'h01, 16'd4, 0, 0);
      repeat (8) step(0, 8'h00, 16'd4, 0, 0);
      repeat (121) step(0, 8'h00, 16'd8, 0, 0);
      fr0 = {1'b1, 8'h96, 1'b0};
      fr1 = {1'b1, 8'h01, 1'b0};
      for (int k = 1; k <= 40; k++) chk("div_f1_tx", tx_hist[k], fr0[(k-1)/4]);
      for (int k = 41; k <= 120; k++) chk("div_f2_tx", tx_hist[k], fr1[(k-41)/8]);
      chk("div_tx48", tx_hist[48], 1'b0);
      chk("div_tx49", tx_hist[49], 1'b1);
      chk("div_busy120", busy_hist[120], 1'b1);
      chk("div_busy121", busy_hist[121], 1'b0);
      $display("sequence: divisor change mid-frame done");

      // randomized traffic against the model
      do_reset();
      div_i = 16'd3;
      for (int i = 0; i < 4000; i++) begin
         logic [15:0] dv;
         dv = div_i;
         if ($urandom_range(0, 99) < 2) dv = 16'($urandom_range(0, 6));
         step($urandom_range(0, 99) < 35, 8'($urandom), dv,
              $urandom_range(0, 99) < 5, $urandom_range(0, 999) < 3);
      end
      $display("random phase: 4000 cycles done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
